ccw_retry_sched: RTL

//  Sequences recovery of one CCW (command control word) exchange with a subscriber device (SD).
//  - sd_busy: schedules delayed repeats.
//  - No reply or error: switches the command source (main/reserve) and repeats the CCW.
//  - Reports final success or failure.

---
 rtl/ccw_retry_sched_pkg.sv | 28 ++
 rtl/ccw_delay_timer.sv | 40 ++++
 rtl/ccw_retry_sched.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ccw_retry_sched_pkg.sv
// ccw_retry_sched_pkg
//   Shared definitions for the CCW retry scheduler:
//   - default clock frequency, busy delay and retry limits
//   - 3-bit FSM state encoding (CCW_ST_IDLE .. CCW_ST_FAIL)
//   - calc_ticks(): terminal count of the busy-delay counter
package ccw_retry_sched_pkg;

    localparam int unsigned CLK_FREQ_DEF         = 50_000_000;
    localparam int unsigned BUSY_DELAY_MS_DEF    = 100;
    localparam int unsigned MAX_BUSY_RETRIES_DEF = 3;
    localparam int unsigned MAX_SRC_TOGGLES_DEF  = 1;
    localparam int unsigned CNT_W_DEF            = 23;

    typedef enum logic [2:0] {
        CCW_ST_IDLE      = 3'd0,
        CCW_ST_WAIT_RESP = 3'd1,
        CCW_ST_BUSY_DLY  = 3'd2,
        CCW_ST_SWITCH    = 3'd3,
        CCW_ST_FAIL      = 3'd4
    } ccw_state_e;

    // Counter runs 0..TICKS inclusive, so TICKS+1 cycles make up the delay.
    function automatic int unsigned calc_ticks(input int unsigned clk_freq,
                                               input int unsigned delay_ms);
        return clk_freq / 1000 * delay_ms - 1;
    endfunction

endpackage

// File: rtl/ccw_delay_timer.sv
// ccw_delay_timer
//   Busy-delay counter for the CCW retry scheduler.
//   Ports:
//     clk, n_rst  clock, async active-low reset
//     run         counter advances while high, held at 0 while low
//     load        restart the count at 0 (first cycle of a delay)
//     terminal    high while the count equals TICKS
module ccw_delay_timer
    import ccw_retry_sched_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned TICKS = calc_ticks(CLK_FREQ_DEF, BUSY_DELAY_MS_DEF)
) (
    input  logic clk,
    input  logic n_rst,
    input  logic run,
    input  logic load,
    output logic terminal
);

    localparam logic [CNT_W-1:0] TICKS_C = CNT_W'(TICKS);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else if (!run || load) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + ONE_C;
        end
    end

    // The owner leaves the delay state on this cycle, so the count never
    // passes TICKS.
    assign terminal = (cnt_q == TICKS_C);

endmodule

// File: rtl/ccw_retry_sched.sv
// ccw_retry_sched
//   Recovery sequencer for one CCW exchange with a subscriber device.
//   Busy replies schedule delayed repeats; missing or bad replies switch the
//   command source (main/reserve) and repeat. Reports success or failure.
//   Ports:
//     clk, n_rst               clock, async active-low reset
//     ccw_start                new CCW launched by the transmitter
//     ccw_accepted             SD accepted the CCW
//     sd_busy                  SD replied busy
//     no_reply_or_err          reply timeout or bad reply
//     ccw_repeat_req           retransmit the current CCW
//     ccw_toggle_com_src_req   source switch performed
//     com_src_sel              0 = main, 1 = reserve
//     ccw_done / ccw_fail      exchange succeeded / retries exhausted
//     sched_busy               exchange in progress
//     busy_retry_cnt           busy repeats used on the current source
//   Signalling: every input and every *_req/done/fail output is a single-cycle
//   pulse with no back-pressure; a pulse is consumed on the clock edge that
//   samples it. All outputs come straight from flops.
module ccw_retry_sched
    import ccw_retry_sched_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = CLK_FREQ_DEF,
    parameter int unsigned BUSY_DELAY_MS    = BUSY_DELAY_MS_DEF,
    parameter int unsigned MAX_BUSY_RETRIES = MAX_BUSY_RETRIES_DEF,
    parameter int unsigned MAX_SRC_TOGGLES  = MAX_SRC_TOGGLES_DEF,
    parameter int unsigned CNT_W            = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       ccw_start,
    input  logic       ccw_accepted,
    input  logic       sd_busy,
    input  logic       no_reply_or_err,
    output logic       ccw_repeat_req,
    output logic       ccw_toggle_com_src_req,
    output logic       com_src_sel,
    output logic       ccw_done,
    output logic       ccw_fail,
    output logic       sched_busy,
    output logic [1:0] busy_retry_cnt
);

    localparam int unsigned TICKS = calc_ticks(CLK_FREQ, BUSY_DELAY_MS);
    // One spare code so the width is never zero.
    localparam int unsigned TOG_W = $clog2(MAX_SRC_TOGGLES + 2);
    localparam logic [1:0]       MAX_BUSY_C = 2'(MAX_BUSY_RETRIES);
    localparam logic [TOG_W-1:0] MAX_TOG_C  = TOG_W'(MAX_SRC_TOGGLES);
    localparam logic [TOG_W-1:0] TOG_ONE_C  = TOG_W'(1);

    ccw_state_e       state_q, state_nx;
    logic [1:0]       busy_cnt_nx;
    logic [TOG_W-1:0] tog_cnt_q, tog_cnt_nx;
    logic             src_nx, repeat_nx, toggle_nx, done_nx, fail_nx, sbusy_nx;
    logic             fault;
    logic             tmr_load, tmr_term;

    ccw_delay_timer #(
        .CNT_W (CNT_W),
        .TICKS (TICKS)
    ) u_delay_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .run      (state_nx == CCW_ST_BUSY_DLY),
        .load     (tmr_load),
        .terminal (tmr_term)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q                <= CCW_ST_IDLE;
            tog_cnt_q              <= '0;
            busy_retry_cnt         <= '0;
            com_src_sel            <= 1'b0;
            ccw_repeat_req         <= 1'b0;
            ccw_toggle_com_src_req <= 1'b0;
            ccw_done               <= 1'b0;
            ccw_fail               <= 1'b0;
            sched_busy             <= 1'b0;
        end else begin
            state_q                <= state_nx;
            tog_cnt_q              <= tog_cnt_nx;
            busy_retry_cnt         <= busy_cnt_nx;
            com_src_sel            <= src_nx;
            ccw_repeat_req         <= repeat_nx;
            ccw_toggle_com_src_req <= toggle_nx;
            ccw_done               <= done_nx;
            ccw_fail               <= fail_nx;
            sched_busy             <= sbusy_nx;
        end
    end

    always_comb begin
        state_nx    = state_q;
        busy_cnt_nx = busy_retry_cnt;
        tog_cnt_nx  = tog_cnt_q;
        src_nx      = com_src_sel;
        sbusy_nx    = sched_busy;
        repeat_nx   = 1'b0;
        toggle_nx   = 1'b0;
        done_nx     = 1'b0;
        fail_nx     = 1'b0;
        tmr_load    = 1'b0;
        fault       = 1'b0;

        case (state_q)
            CCW_ST_IDLE: begin
                if (ccw_start) begin
                    state_nx    = CCW_ST_WAIT_RESP;
                    busy_cnt_nx = '0;
                    tog_cnt_nx  = '0;
                    sbusy_nx    = 1'b1;
                end
            end
            CCW_ST_WAIT_RESP: begin
                if (ccw_accepted) begin
                    state_nx = CCW_ST_IDLE;
                    done_nx  = 1'b1;
                    sbusy_nx = 1'b0;
                end else if (no_reply_or_err) begin
                    fault = 1'b1;
                end else if (sd_busy) begin
                    if (busy_retry_cnt < MAX_BUSY_C) begin
                        state_nx    = CCW_ST_BUSY_DLY;
                        busy_cnt_nx = busy_retry_cnt + 2'd1;
                        tmr_load    = 1'b1;
                    end else begin
                        // Busy budget on this source is spent: escalate.
                        fault = 1'b1;
                    end
                end
            end
            CCW_ST_BUSY_DLY: begin
                // Fault and busy pulses are deliberately ignored while waiting.
                if (ccw_accepted) begin
                    state_nx = CCW_ST_IDLE;
                    done_nx  = 1'b1;
                    sbusy_nx = 1'b0;
                end else if (tmr_term) begin
                    state_nx  = CCW_ST_WAIT_RESP;
                    repeat_nx = 1'b1;
                end
            end
            CCW_ST_SWITCH: begin
                // Source flip was announced last cycle; repeat follows alone.
                state_nx  = CCW_ST_WAIT_RESP;
                repeat_nx = 1'b1;
            end
            CCW_ST_FAIL: begin
                state_nx = CCW_ST_IDLE;
            end
            default: begin
                state_nx = CCW_ST_IDLE;
            end
        endcase

        if (fault) begin
            if (tog_cnt_q < MAX_TOG_C) begin
                state_nx    = CCW_ST_SWITCH;
                src_nx      = ~com_src_sel;
                toggle_nx   = 1'b1;
                tog_cnt_nx  = tog_cnt_q + TOG_ONE_C;
                busy_cnt_nx = '0;
            end else begin
                state_nx = CCW_ST_FAIL;
                fail_nx  = 1'b1;
                sbusy_nx = 1'b0;
            end
        end
    end

endmodule
